// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - game level/lives sequencer driving a level loader handshake
// Optional LEVEL_WRAP_EN: clearing the final level wraps to level 0 instead of winning.
module level_sequencer #(
  parameter int NUM_LEVELS    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int START_LIVES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       level_clear,
  input  logic       level_fail,
  input  logic       ld_ready,
  input  logic       ld_done,
  output logic       ld_start,
  output logic [1:0] level_sel,
  output logic [1:0] lives,
  output logic       play_en,
  output logic       busy,
  output logic       game_over,
  output logic       game_won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RELEASE,
    S_SETTLE,
    S_PLAY,
    S_WON,
    S_OVER
  } state_t;

  localparam logic [1:0] LAST_LEVEL  = 2'(NUM_LEVELS - 1);
  localparam logic [1:0] INIT_LIVES  = 2'(START_LIVES);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [1:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      level_q <= 2'd0;
      lives_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state   <= state_next;
      level_q <= level_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_next = state;
    level_d    = level_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    case (state)
      S_IDLE, S_WON, S_OVER: begin
        if (new_game) begin
          level_d    = 2'd0;
          lives_d    = INIT_LIVES;
          state_next = S_START;
        end
      end
      S_START: begin
        if (ld_done) state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (ld_ready) begin
          cnt_d      = SETTLE_LOAD;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // counter was preloaded on entry, so zero marks the last settle cycle
        if (cnt_q == 8'd0) state_next = S_PLAY;
        else               cnt_d      = cnt_q - 8'd1;
      end
      S_PLAY: begin
        if (level_clear) begin
          if (level_q < LAST_LEVEL) begin
            level_d    = level_q + 2'd1;
            state_next = S_START;
          end else begin
`ifdef LEVEL_WRAP_EN
            level_d    = 2'd0;
            state_next = S_START;
`else
            state_next = S_WON;
`endif
          end
        end else if (level_fail) begin
          if (lives_q > 2'd1) begin
            lives_d    = lives_q - 2'd1;
            state_next = S_START;
          end else begin
            lives_d    = 2'd0;
            state_next = S_OVER;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ld_start  = (state == S_START);
  assign busy      = (state == S_START) || (state == S_RELEASE) || (state == S_SETTLE);
  assign play_en   = (state == S_PLAY);
  assign game_over = (state == S_OVER);
  assign game_won  = (state == S_WON);
  assign level_sel = level_q;
  assign lives     = lives_q;

endmodule

// File: tb/tb_level_sequencer.sv
// tb/tb_level_sequencer.sv - directed scoreboard bench for level_sequencer
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       reset, new_game, level_clear, level_fail, ld_ready, ld_done;
  logic       ld_start, play_en, busy, game_over, game_won;
  logic [1:0] level_sel, lives;

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [8:0] exp_q[$];

  level_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .level_clear(level_clear),
    .level_fail (level_fail),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_start   (ld_start),
    .level_sel  (level_sel),
    .lives      (lives),
    .play_en    (play_en),
    .busy       (busy),
    .game_over  (game_over),
    .game_won   (game_won)
  );

  always #5 clk = ~clk;

  // {ld_start, level_sel, lives, play_en, busy, game_over, game_won}
  function automatic logic [8:0] ov(input logic s, input logic [1:0] l, input logic [1:0] lv,
                                    input logic p, input logic b, input logic o, input logic w);
    return {s, l, lv, p, b, o, w};
  endfunction

  function automatic logic [8:0] st_start(input logic [1:0] l, input logic [1:0] lv);
    return ov(1'b1, l, lv, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [8:0] st_busy(input logic [1:0] l, input logic [1:0] lv);
    return ov(1'b0, l, lv, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [8:0] st_play(input logic [1:0] l, input logic [1:0] lv);
    return ov(1'b0, l, lv, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [8:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check();
    string      tag;
    logic [8:0] exp;
    logic [8:0] obs;
    obs = {ld_start, level_sel, lives, play_en, busy, game_over, game_won};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%b expected=<entry>", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic [8:0] exp);
    sb_push(tag, exp);
    tick();
    sb_check();
  endtask

  // Entered with the DUT already in S_START; leaves it in S_PLAY.
  task automatic do_load(input int done_delay, input logic [1:0] l, input logic [1:0] lv);
    int n;
    repeat (done_delay) tick();
    sb_push("start_hold", st_start(l, lv));
    sb_check();
    ld_done = 1'b1;
    step("release", st_busy(l, lv));
    ld_done = 1'b0;
    ld_ready = 1'b1;
    step("settle_entry", st_busy(l, lv));
    ld_ready = 1'b0;
    sb_push("play_entry", st_play(l, lv));
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    checks++;
    assert (n === 16) else begin
      errors++;
      $error("FAIL settle_cycles observed=%0d expected=16", n);
    end
    sb_check();
  endtask

  initial begin
    reset = 1'b1; new_game = 1'b0; level_clear = 1'b0; level_fail = 1'b0;
    ld_ready = 1'b0; ld_done = 1'b0;
    tick();
    step("reset_state", 9'd0);
    reset = 1'b0;

    new_game = 1'b1;
    step("new_game", st_start(2'd0, 2'd3));
    new_game = 1'b0;
    do_load(60, 2'd0, 2'd3);

    level_clear = 1'b1;
    step("clear_l0", st_start(2'd1, 2'd3));
    level_clear = 1'b0;
    do_load(3, 2'd1, 2'd3);

    level_clear = 1'b1; level_fail = 1'b1;
    step("clear_fail_prio", st_start(2'd2, 2'd3));
    level_clear = 1'b0; level_fail = 1'b0;
    level_fail = 1'b1;
    step("fail_ignored_start", st_start(2'd2, 2'd3));
    level_fail = 1'b0;
    do_load(2, 2'd2, 2'd3);

    level_fail = 1'b1;
    step("fail_1", st_start(2'd2, 2'd2));
    level_fail = 1'b0;
    do_load(2, 2'd2, 2'd2);
    level_fail = 1'b1;
    step("fail_2", st_start(2'd2, 2'd1));
    level_fail = 1'b0;
    do_load(2, 2'd2, 2'd1);
    level_fail = 1'b1;
    step("fail_3_over", ov(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    level_fail = 1'b0;
    level_clear = 1'b1;
    step("clear_ignored_over", ov(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    level_clear = 1'b0;

    new_game = 1'b1;
    step("restart", st_start(2'd0, 2'd3));
    new_game = 1'b0;
    for (int l = 0; l < 3; l++) begin
      do_load(1, 2'(l), 2'd3);
      level_clear = 1'b1;
      step("advance", st_start(2'(l + 1), 2'd3));
      level_clear = 1'b0;
    end
    do_load(1, 2'd3, 2'd3);
    level_clear = 1'b1;
`ifdef LEVEL_WRAP_EN
    step("wrap", st_start(2'd0, 2'd3));
    level_clear = 1'b0;
    do_load(1, 2'd0, 2'd3);
    new_game = 1'b1;
    step("ng_ignored_play", st_play(2'd0, 2'd3));
    new_game = 1'b0;
    level_clear = 1'b1;
    step("clear_after_wrap", st_start(2'd1, 2'd3));
    level_clear = 1'b0;
`else
    step("won", ov(1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    level_clear = 1'b0;
    level_fail = 1'b1;
    step("fail_ignored_won", ov(1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    level_fail = 1'b0;
    new_game = 1'b1;
    step("restart_won", st_start(2'd0, 2'd3));
    new_game = 1'b0;
`endif

    reset = 1'b1;
    step("reset_mid_load", 9'd0);
    reset = 1'b0;
    step("idle_hold", 9'd0);
    new_game = 1'b1;
    step("new_game_after_reset", st_start(2'd0, 2'd3));
    new_game = 1'b0;
    do_load(5, 2'd0, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
